// File: rtl/opt_enc_pkg.sv
// opt_enc_pkg: shared constants for the one-time-pad byte encryptor.
//   DEPTH      - number of stored pad bytes (power of two)
//   SEED/TAPS  - LFSR reset state and Fibonacci feedback taps
//   *_BIT      - bit positions inside uio_in / uio_out
//   UIO_OE     - constant output-enable pattern for the bidirectional pins
package opt_enc_pkg;
   localparam int DEPTH = 8;
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [7:0] SEED = 8'hA5;
   localparam logic [7:0] TAPS = 8'hB8;   // x^8+x^6+x^5+x^4+1

   localparam int MODE_BIT      = 7;
   localparam int VALID_BIT     = 1;
   localparam int OUT_VALID_BIT = 6;
   localparam int ERROR_BIT     = 5;
   localparam int FULL_BIT      = 4;

   localparam logic [7:0] UIO_OE = 8'b0111_0000;

   typedef enum logic {
      MODE_ENC = 1'b0,
      MODE_DEC = 1'b1
   } mode_e;

   // One Fibonacci step: shift left, feedback is parity of tapped bits.
   function automatic logic [7:0] lfsr_next(input logic [7:0] s);
      return {s[6:0], ^(s & TAPS)};
   endfunction
endpackage

// File: rtl/opt_key_regfile.sv
// opt_key_regfile: DEPTH x 8 pad store, one write port, one read port.
//   clk   - clock, rising edge
//   reset - synchronous active-high clear of all entries
//   we/wa/wd - write enable, address, data (written on clk)
//   a1/rd1   - combinational read address / data
module opt_key_regfile
   import opt_enc_pkg::*;
#(
   parameter int N  = DEPTH,
   parameter int AW = $clog2(N)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          we,
   input  logic [AW-1:0] wa,
   input  logic [7:0]    wd,
   input  logic [AW-1:0] a1,
   output logic [7:0]    rd1
);

   logic [7:0] r_mem [N];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++) r_mem[i] <= 8'h00;
      end else if (we) begin
         r_mem[wa] <= wd;
      end
   end

   assign rd1 = r_mem[a1];

endmodule

// File: rtl/opt_encryptor.sv
// opt_encryptor: one-time-pad byte encryptor/decryptor behind TT wrapper pins.
//   clk, rst_n - clock and synchronous active-low reset
//   ena        - global enable; 0 freezes all state
//   ui_in      - plaintext (encrypt) or ciphertext (decrypt) byte
//   uio_in     - [7] mode (0 enc / 1 dec), [1] valid
//   uo_out     - registered result byte
//   uio_out    - [6] out_valid, [5] error, [4] full
//   uio_oe     - constant output enables
// Encrypt XORs with a fresh LFSR byte and queues that byte; decrypt XORs
// with the oldest queued byte and pops it.
module opt_encryptor
   import opt_enc_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   logic [7:0]       r_lfsr;
   logic [7:0]       r_out;
   logic             r_out_valid;
   logic             r_error;
   logic [PTR_W-1:0] r_wptr;
   logic [PTR_W-1:0] r_rptr;
   logic [CNT_W-1:0] r_count;

   mode_e      w_mode;
   logic       w_req;
   logic       w_enc_ok;
   logic       w_dec_ok;
   logic       w_accept;
   logic       w_reject;
   logic       w_full;
   logic [7:0] w_key;
   logic       w_unused;

   assign w_mode   = mode_e'(uio_in[MODE_BIT]);
   assign w_req    = ena & uio_in[VALID_BIT];
   assign w_full   = (r_count == CNT_W'(DEPTH));
   assign w_enc_ok = w_req && (w_mode == MODE_ENC) && !w_full;
   assign w_dec_ok = w_req && (w_mode == MODE_DEC) && (r_count != '0);
   assign w_accept = w_enc_ok | w_dec_ok;
   assign w_reject = w_req & ~w_accept;
   assign w_unused = ^{uio_in[6:2], uio_in[0]};

   opt_key_regfile #(.N(DEPTH), .AW(PTR_W)) u_keys (
      .clk   (clk),
      .reset (~rst_n),
      .we    (w_enc_ok),
      .wa    (r_wptr),
      .wd    (r_lfsr),
      .a1    (r_rptr),
      .rd1   (w_key)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_lfsr      <= SEED;
         r_out       <= 8'h00;
         r_out_valid <= 1'b0;
         r_error     <= 1'b0;
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
      end else begin
         // status flags are single-cycle pulses; they clear on any other cycle
         r_out_valid <= w_accept;
         r_error     <= w_reject;
         if (w_enc_ok) begin
            r_out   <= ui_in ^ r_lfsr;
            r_lfsr  <= lfsr_next(r_lfsr);
            r_wptr  <= r_wptr + 1'b1;
            r_count <= r_count + 1'b1;
         end else if (w_dec_ok) begin
            r_out   <= ui_in ^ w_key;
            r_rptr  <= r_rptr + 1'b1;
            r_count <= r_count - 1'b1;
         end
      end
   end

   always_comb begin
      uio_out                = 8'h00;
      uio_out[OUT_VALID_BIT] = r_out_valid;
      uio_out[ERROR_BIT]     = r_error;
      uio_out[FULL_BIT]      = w_full;
   end

   assign uo_out = r_out;
   assign uio_oe = UIO_OE;

endmodule

// File: tb/tb_opt_encryptor.sv
// tb_opt_encryptor: directed vectors with hand-computed pad bytes.
// Pad sequence from SEED A5: A5 4A 95 2A 54 A9 53 A7 4E
module tb_opt_encryptor;

   logic       clk;
   logic       rst_n;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int n_chk  = 0;
   int n_pass = 0;

   localparam logic [7:0] ENC = 8'h02;
   localparam logic [7:0] DEC = 8'h82;
   localparam logic [7:0] IDL = 8'h00;
   // status patterns on uio_out
   localparam logic [7:0] S_NONE = 8'h00;
   localparam logic [7:0] S_OV   = 8'h40;
   localparam logic [7:0] S_ERR  = 8'h20;
   localparam logic [7:0] S_FULL = 8'h10;

   logic [7:0] pads [9] = '{8'hA5, 8'h4A, 8'h95, 8'h2A, 8'h54,
                            8'hA9, 8'h53, 8'hA7, 8'h4E};

   opt_encryptor dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %02h expected %02h", tag, got, exp);
   endtask

   // apply inputs away from the edge, then sample just after the edge
   task automatic cyc(input logic [7:0] ui, input logic [7:0] uio, input logic en);
      @(negedge clk);
      ui_in  = ui;
      uio_in = uio;
      ena    = en;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n  = 1'b0;
      ena    = 1'b1;
      ui_in  = 8'h00;
      uio_in = IDL;
      @(posedge clk);
      #1;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n  = 1'b0;
      ena    = 1'b0;
      ui_in  = 8'h00;
      uio_in = 8'h00;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_uo", uo_out, 8'h00);
      chk("rst_status", uio_out, S_NONE);
      chk("uio_oe", uio_oe, 8'h70);
      @(negedge clk);
      rst_n = 1'b1;

      // single encrypt after reset
      cyc(8'hFF, ENC, 1'b1);
      chk("enc1_uo", uo_out, 8'h5A);
      chk("enc1_status", uio_out, S_OV);
      cyc(8'h33, IDL, 1'b1);
      chk("idle_uo", uo_out, 8'h5A);
      chk("idle_status", uio_out, S_NONE);

      // two encrypts, two decrypts in FIFO order
      do_reset();
      cyc(8'hFF, ENC, 1'b1);
      chk("enc_a", uo_out, 8'h5A);
      cyc(8'hFF, ENC, 1'b1);
      chk("enc_b", uo_out, 8'hB5);
      cyc(8'h5A, DEC, 1'b1);
      chk("dec_a", uo_out, 8'hFF);
      chk("dec_a_status", uio_out, S_OV);
      cyc(8'hB5, DEC, 1'b1);
      chk("dec_b", uo_out, 8'hFF);
      cyc(8'h11, DEC, 1'b1);
      chk("dec_empty_status", uio_out, S_ERR);
      chk("dec_empty_uo", uo_out, 8'hFF);

      // decrypt straight after reset
      do_reset();
      cyc(8'h77, DEC, 1'b1);
      chk("underflow_status", uio_out, S_ERR);
      chk("underflow_uo", uo_out, 8'h00);
      cyc(8'h77, IDL, 1'b1);
      chk("err_pulse_clear", uio_out, S_NONE);

      // fill to DEPTH; plaintext 00 exposes raw pads
      do_reset();
      for (int i = 0; i < 8; i++) begin
         cyc(8'h00, ENC, 1'b1);
         chk($sformatf("fill_uo%0d", i), uo_out, pads[i]);
      end
      chk("full_status", uio_out, S_OV | S_FULL);
      cyc(8'hFF, ENC, 1'b1);
      chk("overflow_status", uio_out, S_ERR | S_FULL);
      chk("overflow_uo", uo_out, pads[7]);
      cyc(8'h00, DEC, 1'b1);
      chk("pop0_uo", uo_out, pads[0]);
      chk("pop0_status", uio_out, S_OV);
      // lfsr must not have advanced on the rejected encrypt
      cyc(8'h00, ENC, 1'b1);
      chk("lfsr_hold_uo", uo_out, pads[8]);
      chk("refull_status", uio_out, S_OV | S_FULL);

      // ena low freezes everything
      for (int i = 0; i < 3; i++) begin
         cyc(8'hC3, (i == 1) ? DEC : ENC, 1'b0);
         chk($sformatf("ena0_uo%0d", i), uo_out, pads[8]);
         chk($sformatf("ena0_status%0d", i), uio_out, S_FULL);
      end
      cyc(8'h00, DEC, 1'b1);
      chk("after_ena0_pop", uo_out, pads[1]);

      // mixed mode: decrypt with nonzero data
      cyc(8'hF0, DEC, 1'b1);
      chk("mixed_pop2", uo_out, 8'hF0 ^ pads[2]);

      // reset mid-stream discards pads and restarts lfsr
      do_reset();
      for (int i = 0; i < 3; i++) cyc(8'h00, ENC, 1'b1);
      chk("pre_rst_uo", uo_out, pads[2]);
      do_reset();
      cyc(8'h12, DEC, 1'b1);
      chk("post_rst_dec_status", uio_out, S_ERR);
      chk("post_rst_dec_uo", uo_out, 8'h00);
      cyc(8'hFF, ENC, 1'b1);
      chk("post_rst_enc", uo_out, 8'h5A);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   // hard stop in case the stimulus stalls
   initial begin
      #100000;
      $display("FAIL timeout: got stalled expected finish");
      $fatal(1);
   end

endmodule
